canny_reg_engine: RTL and testbench
===================================

CANNY_REG_ENGINE -- requirements
Module: canny_reg_engine

Interface
REQ-001 SHALL have parameter HIGH_TH, default 100: hysteresis strong threshold (8-bit, unsigned).
REQ-002 SHALL have parameter LOW_TH, default 40: hysteresis weak threshold (8-bit, unsigned); LOW_TH <= HIGH_TH.
REQ-003 tclk  input  1  sole clock; all state on rising edge.
REQ-004 rst_b  input  1  asynchronous, active-low reset.
REQ-005 AddrRegRow  input  3  window row index 0..4.
REQ-006 AddrRegCol  input  3  window column index 0..4.
REQ-007 bWE  input  1  0 = write window bank, 1 = read result register.
REQ-008 bCE  input  1  active-low access strobe, sampled each cycle.
REQ-009 InData  input  8  window write data.
REQ-010 OutData  output  8  registered result read data.
REQ-011 OPMode  input  3  0 Gaussian, 1 Sobel, 2 NMS, 3 Hysteresis.
REQ-012 bOPEnable  input  1  active-low operation request, level-sampled.
REQ-013 dReadReg  input  4  result select: 0 Gaussian, 1 gradient, 2 direction, 3 NMS, 4 hysteresis.
REQ-014 dWriteReg  input  4  bank select: 0 X, 1 Y, 2 Z.
REQ-015 Busy  output  1  high while an operation executes.

Function
REQ-016 Three 5x5 8-bit banks X, Y, Z; five 8-bit result registers.
REQ-017 Write: Idle and bOPEnable=1 and bCE=0 and bWE=0 -> bank[dWriteReg][row][col] <= InData in that cycle; row/col > 4 or dWriteReg > 2 -> dropped.
REQ-018 Write while Busy, or in the cycle bOPEnable=0 is sampled, -> dropped.
REQ-019 Read: bCE=0 and bWE=1 -> OutData <= result[dReadReg] on that edge; dReadReg > 4 -> 0; otherwise OutData holds. Reads are allowed while Busy and return the pre-operation value.
REQ-020 FSM states: IDLE, RUN, DONE. IDLE -> RUN on first edge with bOPEnable=0; Busy=1 from the next cycle.
REQ-021 bOPEnable held low after DONE does not retrigger; re-arm requires bOPEnable=1 for at least one cycle. bOPEnable rising during RUN does not abort.
REQ-022 Gaussian: one window row per RUN cycle (5 products), 5 cycles; kernel rows [2 4 5 4 2], [4 9 12 9 4], [5 12 15 12 5], [4 9 12 9 4], [2 4 5 4 2]; 16-bit accumulator; result = floor(sum/159), written at DONE (start+6).
REQ-023 Sobel (X rows/cols 0..2): Gx = right column minus left column; Gy = bottom row minus top row; weights 1,2,1; 11-bit signed.
REQ-024 Sobel gradient = min(255, |Gx|+|Gy|).
REQ-025 Sobel direction, with a=|Gx|, b=|Gy|: 5b<2a -> 0; else 2b>5a -> 90; else same sign of Gx and Gy -> 45; else 135. Both results written at start+2.
REQ-026 NMS: center X[1][1]; direction Y[1][1]; neighbours 0 -> X[1][0],X[1][2]; 90 -> X[0][1],X[2][1]; 45 -> X[0][2],X[2][0]; 135 -> X[0][0],X[2][2]. Result = center if center >= both neighbours, else 0. Other direction values -> 0. Written at start+2.
REQ-027 Hysteresis: result 1 if X[1][1] >= HIGH_TH; 1 if X[1][1] >= LOW_TH and any non-center Z[r][c] (r,c in 0..2) is nonzero; else 0. Y is ignored. Written at start+2.
REQ-028 OPMode 4..7: no result changes; DONE at start+2.
REQ-029 DONE -> IDLE after one cycle; Busy=0 in IDLE.

Reset
REQ-030 rst_b low, asynchronous: FSM to IDLE, Busy=0, OutData=0, all banks and results 0, accumulator 0; this aborts any RUN in progress with no result update.

Structure
REQ-031 Shared package canny_pkg holds mode, read-register and write-bank codes, DATA_WIDTH=8, and the Gaussian kernel constant.
REQ-032 One sub-module canny_sobel_dir: combinational Gx/Gy to gradient and direction quantizer.

Verification
REQ-033 X all 100, Gaussian -> Busy for 6 cycles; read dReadReg=0 -> 100.
REQ-034 X 3x3 rows all [0,7,255], Sobel -> gradient 255, direction 0.
REQ-035 NMS with X[1][1]=50 and X[1][0]=60: Y[1][1]=0 -> 0; Y[1][1]=90 with X[0][1]=X[2][1]=10 -> 50.
REQ-036 Hysteresis with HIGH_TH=100 and LOW_TH=40: X[1][1]=60 and Z all 0 -> 0; Z[0][0]=1 -> 1; X[1][1]=120 -> 1.
REQ-037 rst_b low at start+3 of a Gaussian -> Busy=0, OutData=0, and read Gaussian = 0.
REQ-038 Write issued while Busy, and a write with AddrRegRow=5 -> bank contents unchanged, verified by a subsequent Gaussian result.

Source files
------------

// File: rtl/canny_pkg.sv
// Shared codes and constants for the Canny register engine: operation modes,
// result/bank selects, direction codes, FSM states and the Gaussian kernel.
package canny_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_GAUSS = 3'd0,
    OP_SOBEL = 3'd1,
    OP_NMS   = 3'd2,
    OP_HYST  = 3'd3
  } op_mode_e;

  typedef enum logic [3:0] {
    RD_GAUSS = 4'd0,
    RD_GRAD  = 4'd1,
    RD_DIR   = 4'd2,
    RD_NMS   = 4'd3,
    RD_HYST  = 4'd4
  } read_reg_e;

  typedef enum logic [3:0] {
    BANK_X = 4'd0,
    BANK_Y = 4'd1,
    BANK_Z = 4'd2
  } write_bank_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [DATA_WIDTH-1:0] DIR_0   = 8'd0;
  localparam logic [DATA_WIDTH-1:0] DIR_45  = 8'd45;
  localparam logic [DATA_WIDTH-1:0] DIR_90  = 8'd90;
  localparam logic [DATA_WIDTH-1:0] DIR_135 = 8'd135;

  // 5x5 Gaussian weights; they sum to GAUSS_NORM.
  localparam logic [0:4][0:4][3:0] GAUSS_K = '{
    '{4'd2, 4'd4,  4'd5,  4'd4, 4'd2},
    '{4'd4, 4'd9,  4'd12, 4'd9, 4'd4},
    '{4'd5, 4'd12, 4'd15, 4'd12, 4'd5},
    '{4'd4, 4'd9,  4'd12, 4'd9, 4'd4},
    '{4'd2, 4'd4,  4'd5,  4'd4, 4'd2}
  };
  localparam logic [15:0] GAUSS_NORM = 16'd159;

endpackage

// File: rtl/canny_sobel_dir.sv
// Combinational 3x3 Sobel: gradient magnitude (|Gx|+|Gy| saturated to 255)
// and direction quantized to 0/45/90/135.
module canny_sobel_dir
  import canny_pkg::*;
(
  input  logic [2:0][2:0][DATA_WIDTH-1:0] win,
  output logic [DATA_WIDTH-1:0]           grad,
  output logic [DATA_WIDTH-1:0]           dir
);

  logic [10:0]        left, right, top, bottom;
  logic signed [10:0] gx, gy;
  logic [10:0]        ax, ay;
  logic [11:0]        mag;
  logic [13:0]        a2, a5, b2, b5;

  always_comb begin
    left   = {3'b0, win[0][0]} + {2'b0, win[1][0], 1'b0} + {3'b0, win[2][0]};
    right  = {3'b0, win[0][2]} + {2'b0, win[1][2], 1'b0} + {3'b0, win[2][2]};
    top    = {3'b0, win[0][0]} + {2'b0, win[0][1], 1'b0} + {3'b0, win[0][2]};
    bottom = {3'b0, win[2][0]} + {2'b0, win[2][1], 1'b0} + {3'b0, win[2][2]};
    // Magnitudes stay within +/-1020, so 11-bit two's complement cannot wrap.
    gx = $signed(right - left);
    gy = $signed(bottom - top);
    ax = gx[10] ? (11'd0 - $unsigned(gx)) : $unsigned(gx);
    ay = gy[10] ? (11'd0 - $unsigned(gy)) : $unsigned(gy);
    mag  = {1'b0, ax} + {1'b0, ay};
    grad = (mag > 12'd255) ? 8'd255 : mag[7:0];
    a2 = {2'b0, ax, 1'b0};
    a5 = {3'b0, ax} + {1'b0, ax, 2'b0};
    b2 = {2'b0, ay, 1'b0};
    b5 = {3'b0, ay} + {1'b0, ay, 2'b0};
    if (b5 < a2)               dir = DIR_0;
    else if (b2 > a5)          dir = DIR_90;
    else if (gx[10] == gy[10]) dir = DIR_45;
    else                       dir = DIR_135;
  end

endmodule

// File: rtl/canny_reg_engine.sv
// Register-mapped Canny engine: three 5x5 window banks, an IDLE/RUN/DONE
// sequencer and five result registers read back through OutData.
module canny_reg_engine
  import canny_pkg::*;
#(
  parameter logic [7:0] HIGH_TH = 8'd100,
  parameter logic [7:0] LOW_TH  = 8'd40
) (
  input  logic                  tclk,
  input  logic                  rst_b,
  input  logic [2:0]            AddrRegRow,
  input  logic [2:0]            AddrRegCol,
  input  logic                  bWE,
  input  logic                  bCE,
  input  logic [DATA_WIDTH-1:0] InData,
  output logic [DATA_WIDTH-1:0] OutData,
  input  logic [2:0]            OPMode,
  input  logic                  bOPEnable,
  input  logic [3:0]            dReadReg,
  input  logic [3:0]            dWriteReg,
  output logic                  Busy,
  output state_e                dbg_state
);

  state_e      state, state_n;
  logic [2:0]  op_q;
  logic [2:0]  cnt;
  logic        armed;
  logic        start;
  logic        wr_en;
  logic [15:0] acc, row_sum, gauss_div;

  logic [4:0][4:0][DATA_WIDTH-1:0] bank_x, bank_y, bank_z;
  logic [2:0][2:0][DATA_WIDTH-1:0] win;
  logic [DATA_WIDTH-1:0] res_gauss, res_grad, res_dir, res_nms, res_hyst;
  logic [DATA_WIDTH-1:0] sob_grad, sob_dir, center, n_a, n_b, nms_val, rd_mux;
  logic dir_ok, z_any, hyst_val;

  // armed drops on a start and only returns once bOPEnable is seen high,
  // so a held-low request fires exactly once.
  assign start     = (state == ST_IDLE) && !bOPEnable && armed;
  assign wr_en     = (state == ST_IDLE) && bOPEnable && !bCE && !bWE &&
                     (AddrRegRow <= 3'd4) && (AddrRegCol <= 3'd4);
  assign Busy      = (state != ST_IDLE);
  assign dbg_state = state;

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (start) state_n = ST_RUN;
      ST_RUN:  if (op_q != OP_GAUSS || cnt == 3'd4) state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    row_sum = '0;
    for (int c = 0; c < 5; c++)
      row_sum = row_sum + 16'(GAUSS_K[cnt][c]) * 16'(bank_x[cnt][c]);
    gauss_div = acc / GAUSS_NORM;
  end

  always_ff @(posedge tclk or negedge rst_b) begin
    if (!rst_b) begin
      state <= ST_IDLE;
      op_q  <= '0;
      cnt   <= '0;
      armed <= 1'b1;
      acc   <= '0;
    end else begin
      state <= state_n;
      if (bOPEnable)  armed <= 1'b1;
      else if (start) armed <= 1'b0;
      if (start) begin
        op_q <= OPMode;
        cnt  <= '0;
        acc  <= '0;
      end else if (state == ST_RUN && op_q == OP_GAUSS) begin
        acc <= acc + row_sum;
        cnt <= cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge tclk or negedge rst_b) begin
    if (!rst_b) begin
      bank_x <= '0;
      bank_y <= '0;
      bank_z <= '0;
    end else if (wr_en) begin
      case (dWriteReg)
        BANK_X:  bank_x[AddrRegRow][AddrRegCol] <= InData;
        BANK_Y:  bank_y[AddrRegRow][AddrRegCol] <= InData;
        BANK_Z:  bank_z[AddrRegRow][AddrRegCol] <= InData;
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win[r][c] = bank_x[r][c];
  end

  canny_sobel_dir u_sobel (
    .win  (win),
    .grad (sob_grad),
    .dir  (sob_dir)
  );

  always_comb begin
    center = bank_x[1][1];
    n_a    = '0;
    n_b    = '0;
    dir_ok = 1'b1;
    case (bank_y[1][1])
      DIR_0:   begin n_a = bank_x[1][0]; n_b = bank_x[1][2]; end
      DIR_90:  begin n_a = bank_x[0][1]; n_b = bank_x[2][1]; end
      DIR_45:  begin n_a = bank_x[0][2]; n_b = bank_x[2][0]; end
      DIR_135: begin n_a = bank_x[0][0]; n_b = bank_x[2][2]; end
      default: dir_ok = 1'b0;
    endcase
    nms_val  = (dir_ok && center >= n_a && center >= n_b) ? center : '0;
    z_any    = |{bank_z[0][0], bank_z[0][1], bank_z[0][2], bank_z[1][0],
                 bank_z[1][2], bank_z[2][0], bank_z[2][1], bank_z[2][2]};
    hyst_val = (center >= HIGH_TH) || ((center >= LOW_TH) && z_any);
  end

  // Banks are frozen while busy, so results can be taken from them at DONE.
  always_ff @(posedge tclk or negedge rst_b) begin
    if (!rst_b) begin
      res_gauss <= '0;
      res_grad  <= '0;
      res_dir   <= '0;
      res_nms   <= '0;
      res_hyst  <= '0;
    end else if (state == ST_DONE) begin
      case (op_q)
        OP_GAUSS: res_gauss <= gauss_div[7:0];
        OP_SOBEL: begin
          res_grad <= sob_grad;
          res_dir  <= sob_dir;
        end
        OP_NMS:   res_nms  <= nms_val;
        OP_HYST:  res_hyst <= {7'd0, hyst_val};
        default:  ;
      endcase
    end
  end

  always_comb begin
    case (dReadReg)
      RD_GAUSS: rd_mux = res_gauss;
      RD_GRAD:  rd_mux = res_grad;
      RD_DIR:   rd_mux = res_dir;
      RD_NMS:   rd_mux = res_nms;
      RD_HYST:  rd_mux = res_hyst;
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge tclk or negedge rst_b) begin
    if (!rst_b)            OutData <= '0;
    else if (!bCE && bWE)  OutData <= rd_mux;
  end

endmodule

// File: tb/tb_canny_reg_engine.sv
// Bench for canny_reg_engine: directed cases plus randomized windows checked
// against an arithmetic model of the window banks and result registers.
module tb_canny_reg_engine;

  logic       tclk = 1'b0;
  logic       rst_b = 1'b0;
  logic [2:0] AddrRegRow = '0, AddrRegCol = '0, OPMode = '0;
  logic       bWE = 1'b1, bCE = 1'b1, bOPEnable = 1'b1;
  logic [7:0] InData = '0;
  logic [7:0] OutData;
  logic [3:0] dReadReg = '0, dWriteReg = '0;
  logic       Busy;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int mx[5][5], my[5][5], mz[5][5];
  int mres[5];
  int gk[5][5];

  canny_reg_engine #(.HIGH_TH(8'd100), .LOW_TH(8'd40)) dut (
    .tclk(tclk), .rst_b(rst_b), .AddrRegRow(AddrRegRow), .AddrRegCol(AddrRegCol),
    .bWE(bWE), .bCE(bCE), .InData(InData), .OutData(OutData), .OPMode(OPMode),
    .bOPEnable(bOPEnable), .dReadReg(dReadReg), .dWriteReg(dWriteReg),
    .Busy(Busy), .dbg_state(dbg_state)
  );

  always #5 tclk = ~tclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        mx[r][c] = 0; my[r][c] = 0; mz[r][c] = 0;
      end
    for (int i = 0; i < 5; i++) mres[i] = 0;
  endtask

  task automatic wr(input int bank, input int row, input int col, input int data);
    @(negedge tclk);
    dWriteReg = 4'(bank); AddrRegRow = 3'(row); AddrRegCol = 3'(col);
    InData = 8'(data); bWE = 1'b0; bCE = 1'b0;
    @(posedge tclk); #1;
    bCE = 1'b1; bWE = 1'b1;
  endtask

  task automatic put(input int bank, input int row, input int col, input int data);
    wr(bank, row, col, data);
    if (bank == 0) mx[row][col] = data & 255;
    if (bank == 1) my[row][col] = data & 255;
    if (bank == 2) mz[row][col] = data & 255;
  endtask

  task automatic rd(input int sel, output logic [7:0] v);
    @(negedge tclk);
    dReadReg = 4'(sel); bWE = 1'b1; bCE = 1'b0;
    @(posedge tclk); #1;
    v = OutData;
    bCE = 1'b1;
  endtask

  function automatic int gauss_ref();
    int s = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) s += gk[r][c] * mx[r][c];
    return s / 159;
  endfunction

  task automatic sobel_ref(output int grad, output int dir);
    int gx, gy, a, b;
    gx = (mx[0][2] + 2 * mx[1][2] + mx[2][2]) - (mx[0][0] + 2 * mx[1][0] + mx[2][0]);
    gy = (mx[2][0] + 2 * mx[2][1] + mx[2][2]) - (mx[0][0] + 2 * mx[0][1] + mx[0][2]);
    a = (gx < 0) ? -gx : gx;
    b = (gy < 0) ? -gy : gy;
    grad = (a + b > 255) ? 255 : a + b;
    if (5 * b < 2 * a)      dir = 0;
    else if (2 * b > 5 * a) dir = 90;
    else if (gx * gy >= 0)  dir = 45;
    else                    dir = 135;
  endtask

  function automatic int nms_ref();
    int c = mx[1][1];
    int n1, n2;
    case (my[1][1])
      0:       begin n1 = mx[1][0]; n2 = mx[1][2]; end
      90:      begin n1 = mx[0][1]; n2 = mx[2][1]; end
      45:      begin n1 = mx[0][2]; n2 = mx[2][0]; end
      135:     begin n1 = mx[0][0]; n2 = mx[2][2]; end
      default: return 0;
    endcase
    return (c >= n1 && c >= n2) ? c : 0;
  endfunction

  function automatic int hyst_ref();
    int any_z = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (!(r == 1 && c == 1) && mz[r][c] != 0) any_z = 1;
    if (mx[1][1] >= 100) return 1;
    if (mx[1][1] >= 40 && any_z != 0) return 1;
    return 0;
  endfunction

  task automatic apply_model(input int mode);
    int g, d;
    case (mode)
      0: mres[0] = gauss_ref();
      1: begin sobel_ref(g, d); mres[1] = g; mres[2] = d; end
      2: mres[3] = nms_ref();
      3: mres[4] = hyst_ref();
      default: ;
    endcase
  endtask

  task automatic run_op(input string tag, input int mode);
    int n = 0;
    @(negedge tclk);
    OPMode = 3'(mode); bOPEnable = 1'b0;
    @(posedge tclk); #1;
    bOPEnable = 1'b1;
    while (Busy === 1'b1 && n < 50) begin
      n++;
      @(posedge tclk); #1;
    end
    chk({tag, " busy_cycles"}, n, (mode == 0) ? 6 : 2);
    apply_model(mode);
  endtask

  task automatic check_results(input string tag);
    logic [7:0] v;
    for (int i = 0; i < 5; i++) begin
      rd(i, v);
      chk($sformatf("%s res%0d", tag, i), v, mres[i]);
    end
  endtask

  initial begin
    logic [7:0] v;
    int n, mode, dl[4];
    gk = '{'{2, 4, 5, 4, 2}, '{4, 9, 12, 9, 4}, '{5, 12, 15, 12, 5},
           '{4, 9, 12, 9, 4}, '{2, 4, 5, 4, 2}};
    dl = '{0, 45, 90, 135};
    clear_model();

    // Reset state
    #12;
    chk("reset busy", Busy, 0);
    chk("reset outdata", OutData, 0);
    @(negedge tclk) rst_b = 1'b1;
    check_results("after_reset");
    rd(9, v);
    chk("read sel>4", v, 0);

    // X all 100 -> Gaussian 100, busy 6 cycles
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) put(0, r, c, 100);
    run_op("gauss100", 0);
    rd(0, v);
    chk("gauss100 value", v, 100);

    // Sobel on rows [0,7,255]
    for (int r = 0; r < 3; r++) begin
      put(0, r, 0, 0); put(0, r, 1, 7); put(0, r, 2, 255);
    end
    run_op("sobel_ramp", 1);
    rd(1, v); chk("sobel_ramp grad", v, 255);
    rd(2, v); chk("sobel_ramp dir", v, 0);

    // NMS directed
    put(0, 1, 1, 50); put(0, 1, 0, 60); put(1, 1, 1, 0);
    run_op("nms_dir0", 2);
    rd(3, v); chk("nms_dir0 value", v, 0);
    put(1, 1, 1, 90); put(0, 0, 1, 10); put(0, 2, 1, 10);
    run_op("nms_dir90", 2);
    rd(3, v); chk("nms_dir90 value", v, 50);

    // Hysteresis directed
    put(0, 1, 1, 60);
    run_op("hyst_weak", 3);
    rd(4, v); chk("hyst_weak_alone", v, 0);
    put(2, 0, 0, 1);
    run_op("hyst_linked", 3);
    rd(4, v); chk("hyst_weak_linked", v, 1);
    put(2, 0, 0, 0); put(0, 1, 1, 120);
    run_op("hyst_strong", 3);
    rd(4, v); chk("hyst_strong", v, 1);
    check_results("directed");

    // Held-low request does not retrigger
    @(negedge tclk);
    OPMode = 3'd1; bOPEnable = 1'b0;
    @(posedge tclk); #1;
    n = 0;
    while (Busy === 1'b1 && n < 50) begin n++; @(posedge tclk); #1; end
    chk("held_low busy_cycles", n, 2);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge tclk); #1;
      if (Busy !== 1'b0) n++;
    end
    chk("held_low no_retrigger", n, 0);
    bOPEnable = 1'b1;
    apply_model(1);

    // Writes while busy, out of range and with the start are dropped;
    // reads while busy return the previous result.
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) put(0, r, c, $urandom_range(0, 255));
    @(negedge tclk);
    OPMode = 3'd0; bOPEnable = 1'b0;
    @(posedge tclk); #1;
    bOPEnable = 1'b1;
    wr(0, 0, 0, mx[0][0] ^ 255);
    rd(0, v);
    chk("read_while_busy", v, mres[0]);
    n = 0;
    while (Busy === 1'b1 && n < 50) begin n++; @(posedge tclk); #1; end
    chk("busy_drop wait", n < 50, 1);
    apply_model(0);
    wr(0, 5, 0, 255);
    wr(0, 1, 5, 255);
    wr(3, 2, 2, 255);
    @(negedge tclk);
    dWriteReg = 4'd0; AddrRegRow = 3'd2; AddrRegCol = 3'd2; InData = 8'(mx[2][2] ^ 255);
    bWE = 1'b0; bCE = 1'b0; OPMode = 3'd0; bOPEnable = 1'b0;
    @(posedge tclk); #1;
    bCE = 1'b1; bWE = 1'b1; bOPEnable = 1'b1;
    n = 0;
    while (Busy === 1'b1 && n < 50) begin n++; @(posedge tclk); #1; end
    chk("start_write busy_cycles", n, 6);
    apply_model(0);
    check_results("dropped_writes");

    // Randomized windows and modes
    for (int it = 0; it < 14; it++) begin
      mode = $urandom_range(0, 4);
      if (mode == 4) mode = $urandom_range(4, 7);
      if (mode == 0) begin
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++) put(0, r, c, $urandom_range(0, 255));
      end else begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) put(0, r, c, $urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) put(1, 1, 1, $urandom_range(0, 255));
        else put(1, 1, 1, dl[$urandom_range(0, 3)]);
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) if (mz[r][c] != 0) put(2, r, c, 0);
        if ($urandom_range(0, 1) == 1)
          put(2, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(1, 255));
      end
      run_op($sformatf("rand%0d_mode%0d", it, mode), mode);
      check_results($sformatf("rand%0d", it));
    end

    // Reset during a Gaussian aborts it
    put(0, 1, 1, 200);
    run_op("pre_abort", 3);
    rd(4, v);
    chk("pre_abort hyst", v, 1);
    @(negedge tclk);
    OPMode = 3'd0; bOPEnable = 1'b0;
    @(posedge tclk); #1;
    bOPEnable = 1'b1;
    repeat (2) @(posedge tclk);
    @(posedge tclk); #2;
    rst_b = 1'b0;
    #1;
    chk("abort busy", Busy, 0);
    chk("abort outdata", OutData, 0);
    clear_model();
    @(negedge tclk) rst_b = 1'b1;
    check_results("after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
